jt900h_ldiv: RTL and testbench
==============================

# jt900h_ldiv

Sequential signed/unsigned divider that answers the ALU's `div`/`div_busy` handshake: the ALU asserts a one-cycle start with dividend and divisor, this block iterates one quotient bit per enabled clock and returns quotient, remainder and overflow. It sits beside the ALU inside the CPU datapath and runs on the CPU clock-enable. It handles both TLCS-900H DIV/DIVS forms:
- 32÷16 giving a 16-bit quotient and 16-bit remainder.
- 16÷8 giving an 8-bit quotient and 8-bit remainder.

## Interface
Parameters: none.
- rst    in   1   asynchronous reset, active-high
- clk    in   1   CPU clock
- cen    in   1   clock enable; all state advances only when high
- op0    in   32  dividend (len=0: op0[15:0] used)
- op1    in   16  divisor (len=0: op1[7:0] used)
- len    in   1   1: 32÷16, 0: 16÷8
- sign   in   1   1: two's-complement operands (DIVS)
- start  in   1   begin division; sampled on cen when idle
- quot   out  16  quotient (len=0: [7:0], [15:8]=0)
- rem    out  16  remainder (len=0: [7:0], [15:8]=0)
- busy   out  1   high while a division is in progress
- v      out  1   overflow / divide-by-zero flag

## Operation
- Reset values: quot=0, rem=0, busy=0, v=0, state IDLE.
- States:
  - IDLE: on cen&start, latch operands and go to CALC.
  - CALC: N iterations (N=16 for len=1, 8 for len=0), then go to FIX.
  - FIX: apply signs, load the outputs, return to IDLE.
- Start latch:
  - Magnitudes are taken when sign=1: |dividend| at full width (32 or 16 bit), |divisor| at 16 or 8 bit.
  - Signs are recorded: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
- CALC uses restoring division: shift the partial remainder left 1, subtract the divisor, keep the difference if non-negative, shift in the quotient bit. One iteration per cen cycle.
- Overflow (v=1):
  - Divisor zero.
  - Unsigned magnitude quotient does not fit N bits, i.e. the high half of |dividend| is ≥ |divisor|. This is checked at latch time.
  - Signed: magnitude quotient > 2^(N-1)-1 with a positive result, or > 2^(N-1) with a negative result. This is checked in FIX.
- On overflow: quot = all ones of width N (0xFFFF or 0x00FF), rem = low N bits of the original dividend, v=1. Latency is unchanged.
- Normal result: v=0, quot/rem are the sign-fixed N-bit values.
  - The remainder satisfies |rem| < |divisor|.
  - The remainder is zero or has the dividend's sign.
- quot/rem/v hold their value until the next FIX. They are not cleared by start.
- start while busy=1 is ignored, and the operands are not relatched.
- The operand inputs may change freely after the start cycle.

## Timing
- Start is accepted at cen-edge K. busy=1 from edge K. busy stays high for exactly N+1 cen-enabled edges: 17 for len=1, 9 for len=0.
- busy falls on the same edge that loads quot/rem/v. The ALU may read the results in the first cycle with busy=0.
- cen low freezes state, counter and outputs. busy stays at its current level.
- A back-to-back start is accepted in the first cycle busy=0.
- rst asserted mid-operation: immediate return to IDLE. busy=0, quot=rem=0, v=0. No partial result is retained.

## Structure
- State encoding and the iteration count are local to the module. No package types are needed.
- The 900h_param.vh include is not required.
- Registers:
  - 32-bit partial remainder/dividend shift register.
  - 16-bit divisor.
  - 5-bit iteration counter.
  - Sign bits and an overflow bit.
- Single module with no sub-module. The absolute-value and negate logic is inline and shared between the latch and FIX stages.

## Test plan
- Unsigned 32÷16: op0=0x0001_0000, op1=0x0003, len=1, sign=0 → after 17 cen edges quot=0x5555, rem=0x0001, v=0.
- Unsigned 16÷8: op0=0x0064, op1=0x07, len=0 → after 9 edges quot=0x000E, rem=0x0002, v=0.
- Signed 32÷16: op0=0xFFFF_FFF9 (−7), op1=0x0002, sign=1 → quot=0xFFFD (−3), rem=0xFFFF (−1), v=0.
  - Also op0=0xFFFF_8000, op1=0x0001 → quot=0x8000, v=0.
- Divide by zero and overflow:
  - op1=0, op0=0x1234_5678, len=1 → v=1, quot=0xFFFF, rem=0x5678, 17-edge latency.
  - op0=0x0003_0000, op1=0x0002, unsigned → v=1.
- Handshake: cen toggling 50% → busy spans 34 clocks for len=1.
  - A second start mid-run is ignored; the results match the first operands.
- Reset mid-run: rst at iteration 5 → busy=0, quot=rem=0, v=0 immediately.
  - The next start then completes normally.

Source files
------------

// File: rtl/jt900h_ldiv.sv
// Sequential 32/16 and 16/8 divider for the TLCS-900H DIV/DIVS instructions.
// One restoring-division step per enabled clock; results and v are registered in FIX.
module jt900h_ldiv (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        sign,
  input  logic        start,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        busy,
  output logic        v
);

  // Handshake: start is sampled only on a cen edge while IDLE (busy=0); busy stays
  // high until the FIX edge that loads quot/rem/v, so results are valid once busy=0.
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      st;
  logic [31:0] sr;
  logic [15:0] dvs;
  logic [15:0] dvd_lo;
  logic [4:0]  cnt;
  logic        len_r, sgn_r, qneg, rneg, ovf;

  function automatic logic [31:0] cneg(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

  // Operand magnitudes and the quotient-too-wide check at latch time
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_ext, dvd_abs, dvd_mag, dvs_abs, sr_init;
  logic [15:0] dvs_ext, dvs_mag, dvd_hi;
  logic        latch_ovf;

  always_comb begin
    dvd_neg   = sign & (len ? op0[31] : op0[15]);
    dvs_neg   = sign & (len ? op1[15] : op1[7]);
    dvd_ext   = len ? op0 : {16'd0, op0[15:0]};
    dvs_ext   = len ? op1 : {8'd0, op1[7:0]};
    dvd_abs   = cneg(dvd_ext, dvd_neg);
    dvs_abs   = cneg({16'd0, dvs_ext}, dvs_neg);
    dvd_mag   = len ? dvd_abs : {16'd0, dvd_abs[15:0]};
    dvs_mag   = len ? dvs_abs[15:0] : {8'd0, dvs_abs[7:0]};
    dvd_hi    = len ? dvd_mag[31:16] : {8'd0, dvd_mag[15:8]};
    latch_ovf = (dvs_mag == 16'd0) | (dvd_hi >= dvs_mag);
    // 16/8 is run in the same datapath with the dividend pre-shifted by 8
    sr_init   = len ? dvd_mag : {8'd0, dvd_mag[15:0], 8'd0};
  end

  logic [16:0] part, diff;
  logic        qbit;
  logic [31:0] sr_next;

  always_comb begin
    part    = {sr[31:16], sr[15]};
    diff    = part - {1'b0, dvs};
    qbit    = (part >= {1'b0, dvs});
    sr_next = {(qbit ? diff[15:0] : part[15:0]), sr[14:0], qbit};
  end

  logic [15:0] qm, rm, lim, mask, q_fix, r_fix;
  logic [31:0] q_neg32, r_neg32;
  logic        sovf;

  always_comb begin
    qm      = len_r ? sr[15:0]  : {8'd0, sr[7:0]};
    rm      = len_r ? sr[31:16] : {8'd0, sr[23:16]};
    lim     = len_r ? 16'h8000 : 16'h0080;
    mask    = len_r ? 16'hFFFF : 16'h00FF;
    sovf    = sgn_r & (qneg ? (qm > lim) : (qm >= lim));
    q_neg32 = cneg({16'd0, qm}, qneg);
    r_neg32 = cneg({16'd0, rm}, rneg);
    q_fix   = q_neg32[15:0] & mask;
    r_fix   = r_neg32[15:0] & mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      sr     <= 32'd0;
      dvs    <= 16'd0;
      dvd_lo <= 16'd0;
      cnt    <= 5'd0;
      len_r  <= 1'b0;
      sgn_r  <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      ovf    <= 1'b0;
      quot   <= 16'd0;
      rem    <= 16'd0;
      busy   <= 1'b0;
      v      <= 1'b0;
    end else if (cen) begin
      case (st)
        IDLE: begin
          if (start) begin
            st     <= CALC;
            sr     <= sr_init;
            dvs    <= dvs_mag;
            dvd_lo <= len ? op0[15:0] : {8'd0, op0[7:0]};
            cnt    <= len ? 5'd15 : 5'd7;
            len_r  <= len;
            sgn_r  <= sign;
            qneg   <= dvd_neg ^ dvs_neg;
            rneg   <= dvd_neg;
            ovf    <= latch_ovf;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          sr <= sr_next;
          if (cnt == 5'd0) st <= FIX;
          else cnt <= cnt - 5'd1;
        end
        FIX: begin
          st   <= IDLE;
          busy <= 1'b0;
          if (ovf | sovf) begin
            quot <= mask;
            rem  <= dvd_lo;
            v    <= 1'b1;
          end else begin
            quot <= q_fix;
            rem  <= r_fix;
            v    <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_ldiv.sv
// Directed and random checks of jt900h_ldiv: results, latency, cen stalls,
// ignored mid-run start and asynchronous reset.
module tb_jt900h_ldiv;

  logic        clk = 1'b0;
  logic        rst, cen, len, sign, start;
  logic [31:0] op0;
  logic [15:0] op1;
  logic [15:0] quot, rem;
  logic        busy, v;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_res;

  // clock / reset
  always #5 clk = ~clk;

  jt900h_ldiv dut (
    .rst  (rst),
    .clk  (clk),
    .cen  (cen),
    .op0  (op0),
    .op1  (op1),
    .len  (len),
    .sign (sign),
    .start(start),
    .quot (quot),
    .rem  (rem),
    .busy (busy),
    .v    (v)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: plain integer division, overflow by result range
  function automatic logic [32:0] model(input logic [31:0] a0, input logic [15:0] b0,
                                        input logic l, input logic s);
    longint a, b, q, r, mask, half;
    logic   ov;
    logic [15:0] m16, q16, r16, a16;
    mask = l ? 64'hFFFF : 64'hFF;
    half = l ? 64'd32768 : 64'd128;
    if (l) begin
      if (s) begin a = longint'($signed(a0)); b = longint'($signed(b0)); end
      else begin a = longint'({32'd0, a0}); b = longint'({48'd0, b0}); end
    end else begin
      if (s) begin a = longint'($signed(a0[15:0])); b = longint'($signed(b0[7:0])); end
      else begin a = longint'({48'd0, a0[15:0]}); b = longint'({56'd0, b0[7:0]}); end
    end
    q = 0;
    r = 0;
    if (b == 0) ov = 1'b1;
    else begin
      q  = a / b;
      r  = a % b;
      ov = s ? ((q > half - 1) || (q < -half)) : (q > mask);
    end
    m16 = mask[15:0];
    q16 = q[15:0];
    r16 = r[15:0];
    a16 = a0[15:0];
    return ov ? {1'b1, m16, a16 & m16} : {1'b0, q16 & m16, r16 & m16};
  endfunction

  // driver: one division, scoreboarded; cen_mode 1 = cen alternates 0/1
  task automatic run_div(input logic [31:0] a, input logic [15:0] b, input logic l,
                         input logic s, input logic [32:0] exp, input int cen_mode,
                         input bit mid_start);
    int n, edges, clocks;
    bit done;
    logic [32:0] res;
    n = l ? 16 : 8;
    exp_q.push_back(exp);
    @(negedge clk);
    op0 = a; op1 = b; len = l; sign = s; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op0 = $urandom; op1 = 16'($urandom); len = 1'($urandom); sign = 1'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("hold_quot", {16'd0, quot}, {16'd0, last_res[31:16]});
    check("hold_v", {31'd0, v}, {31'd0, last_res[32]});
    edges = 0; clocks = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cen = (cen_mode == 1) ? 1'(i) : 1'b1;
      start = mid_start && (i == 5);
      @(posedge clk);
      clocks++;
      if (cen) edges++;
      #1;
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    check("timeout", {31'd0, done}, 32'd1);
    check("latency_edges", edges, n + 1);
    if (cen_mode == 1) check("latency_clocks", clocks, 2 * (n + 1));
    res = exp_q.pop_front();
    check("quot", {16'd0, quot}, {16'd0, res[31:16]});
    check("rem", {16'd0, rem}, {16'd0, res[15:0]});
    check("v", {31'd0, v}, {31'd0, res[32]});
    last_res = res;
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] b;
    logic        l, s;
    rst = 1'b1; cen = 1'b0; start = 1'b0; len = 1'b0; sign = 1'b0;
    op0 = 32'd0; op1 = 16'd0;
    last_res = 33'd0;
    repeat (3) @(negedge clk);
    check("rst_quot", {16'd0, quot}, 32'd0);
    check("rst_rem", {16'd0, rem}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_v", {31'd0, v}, 32'd0);
    rst = 1'b0;

    run_div(32'h0001_0000, 16'h0003, 1, 0, {1'b0, 16'h5555, 16'h0001}, 0, 0);
    run_div(32'h0000_0064, 16'h0007, 0, 0, {1'b0, 16'h000E, 16'h0002}, 0, 0);
    run_div(32'hFFFF_FFF9, 16'h0002, 1, 1, {1'b0, 16'hFFFD, 16'hFFFF}, 0, 0);
    run_div(32'hFFFF_8000, 16'h0001, 1, 1, {1'b0, 16'h8000, 16'h0000}, 0, 0);
    run_div(32'h0000_8000, 16'h0001, 1, 1, {1'b1, 16'hFFFF, 16'h8000}, 0, 0);
    run_div(32'h0000_FF80, 16'h00FF, 0, 1, {1'b1, 16'h00FF, 16'h0080}, 0, 0);
    run_div(32'h1234_5678, 16'h0000, 1, 0, {1'b1, 16'hFFFF, 16'h5678}, 0, 0);
    run_div(32'h0003_0000, 16'h0002, 1, 0, {1'b1, 16'hFFFF, 16'h0000}, 0, 0);
    run_div(32'h0000_FF9C, 16'h0007, 0, 1, {1'b0, 16'h00F2, 16'h00FE}, 0, 0);
    run_div(32'h0001_0000, 16'h0003, 1, 0, {1'b0, 16'h5555, 16'h0001}, 1, 0);
    run_div(32'h0000_0064, 16'h0007, 0, 0, {1'b0, 16'h000E, 16'h0002}, 1, 0);
    run_div(32'h0000_03E8, 16'h0007, 1, 0, {1'b0, 16'h008E, 16'h0006}, 0, 1);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    op0 = 32'h0001_0000; op1 = 16'h0003; len = 1'b1; sign = 1'b0; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_quot", {16'd0, quot}, 32'd0);
    check("midrst_rem", {16'd0, rem}, 32'd0);
    check("midrst_v", {31'd0, v}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = 33'd0;
    run_div(32'h0000_0064, 16'h0007, 0, 0, {1'b0, 16'h000E, 16'h0002}, 0, 0);

    for (int k = 0; k < 16; k++) begin
      a = $urandom >> $urandom_range(0, 24);
      b = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      l = 1'($urandom);
      s = 1'($urandom);
      run_div(a, b, l, s, model(a, b, l, s), int'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
